// File: rtl/demux_router_pkg.sv
// Shared definitions for the demux_router slice: global width macros,
// slot count, code width and the destination decode helper.

`ifndef DEMUX_ROUTER_DEFS
`define DEMUX_ROUTER_DEFS
`define DATA_W 32
`define DEMUX_N 8
`define COM_W 4
// Lowest code that falls into the slot-7 catch-all leg.
`define DEMUX_CATCH_ALL 4'b0111
`endif

package demux_router_pkg;

    localparam int DEMUX_N = `DEMUX_N;
    localparam int COM_W   = `COM_W;
    localparam int SLOT_W  = $clog2(DEMUX_N);

    // Map a destination code to a slot index; every code from the catch-all
    // value upward lands in the last slot, mirroring the 8:1 mux default leg.
    function automatic logic [SLOT_W-1:0] decode_dest(input logic [COM_W-1:0] com);
        logic [SLOT_W-1:0] dest;
        dest = SLOT_W'(DEMUX_N - 1);
        if (com < `DEMUX_CATCH_ALL) begin
            dest = com[SLOT_W-1:0];
        end else begin
            dest = SLOT_W'(DEMUX_N - 1);
        end
        return dest;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a word and its valid flag, loads from the
// router and is emptied by its consumer's ready.

module demux_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              take,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              ready
);

    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    // Slot storage: a load wins over a take so a same-cycle drain+load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= data_in;
            valid_r <= 1'b1;
        end else if (take) begin
            valid_r <= 1'b0;
        end
    end

    assign data  = data_r;
    assign valid = valid_r;
    // Space is available when empty or when the held word leaves this cycle.
    assign ready = !valid_r || take;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-8 demultiplexer: decodes the destination code, steers the
// producer word into one of eight single-entry slots and counts stall cycles.

`ifndef DATA_W
`define DATA_W 32
`endif

module demux_router
    import demux_router_pkg::*;
#(
    parameter int DATA_W = `DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [COM_W-1:0]   in_com,
    output logic               in_ready,
    output logic [DATA_W-1:0]  o0,
    output logic [DATA_W-1:0]  o1,
    output logic [DATA_W-1:0]  o2,
    output logic [DATA_W-1:0]  o3,
    output logic [DATA_W-1:0]  o4,
    output logic [DATA_W-1:0]  o5,
    output logic [DATA_W-1:0]  o6,
    output logic [DATA_W-1:0]  o7,
    output logic [DEMUX_N-1:0] o_valid,
    input  logic [DEMUX_N-1:0] o_ready,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [SLOT_W-1:0]  dest_s;
    logic [DEMUX_N-1:0] slot_ready_s;
    logic [DATA_W-1:0]  slot_data_s [DEMUX_N];
    logic               accept_s;
    logic               stall_s;
    logic [CNT_W-1:0]   stall_cnt_r;

    assign dest_s   = decode_dest(in_com);
    // Ready follows only the addressed slot, never in_valid.
    assign in_ready = slot_ready_s[dest_s];
    assign accept_s = in_valid && in_ready;
    assign stall_s  = in_valid && !in_ready;

    for (genvar gi = 0; gi < DEMUX_N; gi++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (accept_s && (dest_s == SLOT_W'(gi))),
            .take   (o_ready[gi]),
            .data_in(in_data),
            .data   (slot_data_s[gi]),
            .valid  (o_valid[gi]),
            .ready  (slot_ready_s[gi])
        );
    end

    assign o0 = slot_data_s[0];
    assign o1 = slot_data_s[1];
    assign o2 = slot_data_s[2];
    assign o3 = slot_data_s[3];
    assign o4 = slot_data_s[4];
    assign o5 = slot_data_s[5];
    assign o6 = slot_data_s[6];
    assign o7 = slot_data_s[7];

    // Saturating stall counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule
